serial_pad_poller: RTL and testbench

- Parametrised successor to the single-pad NES reader.
- Polls CHANNELS serial game pads in parallel. All pads share one latch line and one clock line; each pad has its own data line.
- Reads BITS bits per frame, so it covers NES (8) and SNES (16) pads.
- Autonomous poll rate, registered button state, press/release edge strobes and a frame-valid pulse. Sits between the pad connectors and game logic.

---
 rtl/serial_pad_pkg.sv | 24 ++
 rtl/pad_tick_div.sv | 31 +++
 rtl/serial_pad_poller.sv | 261 ++++++++++++++++++++++++++
 tb/tb_serial_pad_poller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pad_pkg.sv
// Shared types and helpers for the serial game-pad poller.
package serial_pad_pkg;

   localparam int NES_BITS  = 8;
   localparam int SNES_BITS = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      CLK_HI = 3'd2,
      CLK_LO = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/pad_tick_div.sv
// Loadable phase down-counter: loaded with (length-1) on phase entry,
// flags the final cycle of the phase while run is high.
module pad_tick_div #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         run,
   output logic         tick
);

   logic [W-1:0] cnt_r;

   // Reload at phase entry, otherwise count down to zero and hold there.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != '0) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = run && (cnt_r == '0);

endmodule

// File: rtl/serial_pad_poller.sv
// Polls CHANNELS serial game pads sharing latch/clock lines.
// Optional macro SERIAL_PAD_PRESENT_EN adds a per-channel presence detect
// bit sampled on one extra pad-clock pulse, plus the present output.
module serial_pad_poller
   import serial_pad_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int BITS     = NES_BITS,
   parameter int HALF_DIV = 300,
   parameter int POLL_DIV = 833333
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [CHANNELS-1:0]      pad_data,
   output logic                     pad_latch,
   output logic                     pad_clk,
   output logic [CHANNELS*BITS-1:0] buttons,
   output logic [CHANNELS*BITS-1:0] pressed,
   output logic [CHANNELS*BITS-1:0] released,
   output logic                     frame_valid,
   output logic                     busy
`ifdef SERIAL_PAD_PRESENT_EN
   ,
   output logic [CHANNELS-1:0]      present
`endif
);

   localparam int POLL_W = cnt_width(POLL_DIV);
   localparam int DIV_W  = cnt_width(2 * HALF_DIV);
   localparam int IDX_W  = cnt_width(BITS);

   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);
   localparam logic [DIV_W-1:0]  LATCH_LOAD = DIV_W'(2 * HALF_DIV - 1);
   localparam logic [DIV_W-1:0]  HALF_LOAD  = DIV_W'(HALF_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(BITS - 1);
   localparam logic [IDX_W-1:0]  IDX_PENULT = IDX_W'(BITS - 2);

   state_t              state_r, state_n;
   logic [POLL_W-1:0]   poll_cnt_r;
   logic [IDX_W-1:0]    bit_idx_r;
   logic [CHANNELS-1:0] sync1_r, sync2_r;
   logic                pad_latch_r, pad_clk_r, busy_r, frame_valid_r;
   logic                wrap_s, tick_s, run_s, done_s;
   logic                div_load_s, sample_s;
   logic [DIV_W-1:0]    div_val_s;
`ifdef SERIAL_PAD_PRESENT_EN
   logic                det_s;
`endif

   assign wrap_s = (poll_cnt_r == POLL_LAST);
   assign run_s  = (state_r == LATCH) || (state_r == CLK_HI) || (state_r == CLK_LO);
   assign done_s = (state_r == DONE);

   // Free-running frame-rate counter, independent of en and of the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         poll_cnt_r <= '0;
      end else if (wrap_s) begin
         poll_cnt_r <= '0;
      end else begin
         poll_cnt_r <= poll_cnt_r + POLL_W'(1);
      end
   end

   // Two-flop synchroniser on the asynchronous pad data lines.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= pad_data;
         sync2_r <= sync1_r;
      end
   end

   pad_tick_div #(.W(DIV_W)) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (div_load_s),
      .load_val (div_val_s),
      .run      (run_s),
      .tick     (tick_s)
   );

   // Next-state logic: phase sequencing, divider reloads and sample strobes.
   always_comb begin
      state_n    = state_r;
      div_load_s = 1'b0;
      div_val_s  = HALF_LOAD;
      sample_s   = 1'b0;
`ifdef SERIAL_PAD_PRESENT_EN
      det_s      = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (wrap_s && en) begin
               state_n    = LATCH;
               div_load_s = 1'b1;
               div_val_s  = LATCH_LOAD;
            end else begin
               state_n = IDLE;
            end
         end
         LATCH: begin
            if (tick_s) begin
               state_n    = CLK_HI;
               div_load_s = 1'b1;
               sample_s   = 1'b1;
            end else begin
               state_n = LATCH;
            end
         end
         CLK_HI: begin
            if (tick_s) begin
               state_n    = CLK_LO;
               div_load_s = 1'b1;
            end else begin
               state_n = CLK_HI;
            end
         end
         CLK_LO: begin
            if (tick_s) begin
`ifdef SERIAL_PAD_PRESENT_EN
               if (bit_idx_r == IDX_LAST) begin
                  det_s   = 1'b1;
                  state_n = DONE;
               end else begin
                  sample_s   = 1'b1;
                  state_n    = CLK_HI;
                  div_load_s = 1'b1;
               end
`else
               sample_s = 1'b1;
               if (bit_idx_r == IDX_PENULT) begin
                  state_n = DONE;
               end else begin
                  state_n    = CLK_HI;
                  div_load_s = 1'b1;
               end
`endif
            end else begin
               state_n = CLK_LO;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State register, bit index and registered pad/status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         bit_idx_r     <= '0;
         pad_latch_r   <= 1'b0;
         pad_clk_r     <= 1'b0;
         busy_r        <= 1'b0;
         frame_valid_r <= 1'b0;
      end else begin
         state_r       <= state_n;
         pad_latch_r   <= (state_n == LATCH);
         pad_clk_r     <= (state_n == CLK_HI);
         busy_r        <= (state_n != IDLE);
         frame_valid_r <= done_s;
         if (state_r == LATCH) begin
            bit_idx_r <= '0;
         end else if (sample_s) begin
            bit_idx_r <= bit_idx_r + IDX_W'(1);
         end else begin
            bit_idx_r <= bit_idx_r;
         end
      end
   end

   assign pad_latch   = pad_latch_r;
   assign pad_clk     = pad_clk_r;
   assign busy        = busy_r;
   assign frame_valid = frame_valid_r;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [BITS-1:0] shift_r, btn_r, prs_r, rel_r, new_s;

      // Shift in the inverted sample at the top; the first bit lands at bit 0.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            shift_r <= '0;
         end else if (sample_s) begin
            shift_r <= {~sync2_r[c], shift_r[BITS-1:1]};
         end else begin
            shift_r <= shift_r;
         end
      end

`ifdef SERIAL_PAD_PRESENT_EN
      logic det_r, pres_r;

      // Capture the detect bit: a connected pad shifts in a grounded 0.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            det_r <= 1'b0;
         end else if (det_s) begin
            det_r <= ~sync2_r[c];
         end else begin
            det_r <= det_r;
         end
      end

      // Publish presence together with the button update.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            pres_r <= 1'b0;
         end else if (done_s) begin
            pres_r <= det_r;
         end else begin
            pres_r <= pres_r;
         end
      end

      // Absent pads report no buttons so edges are taken against zero.
      always_comb begin
         new_s = '0;
         if (det_r) begin
            new_s = shift_r;
         end else begin
            new_s = '0;
         end
      end

      assign present[c] = pres_r;
`else
      assign new_s = shift_r;
`endif

      // Commit the frame and derive one-cycle press/release strobes.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            btn_r <= '0;
            prs_r <= '0;
            rel_r <= '0;
         end else if (done_s) begin
            btn_r <= new_s;
            prs_r <= new_s & ~btn_r;
            rel_r <= ~new_s & btn_r;
         end else begin
            btn_r <= btn_r;
            prs_r <= '0;
            rel_r <= '0;
         end
      end

      assign buttons[c*BITS +: BITS]  = btn_r;
      assign pressed[c*BITS +: BITS]  = prs_r;
      assign released[c*BITS +: BITS] = rel_r;
   end

endmodule

// File: tb/tb_serial_pad_poller.sv
// Directed bench for serial_pad_poller (HALF_DIV=4, POLL_DIV=200, 2 x 8 bits).
// Build with SERIAL_PAD_PRESENT_EN to exercise presence detect (ch1 floating).
module tb_serial_pad_poller;
   import serial_pad_pkg::*;

   localparam int CH   = 2;
   localparam int BITS = NES_BITS;
`ifdef SERIAL_PAD_PRESENT_EN
   localparam int EXP_PULSES = 8;
   localparam int EXP_FV     = 73;
   localparam logic [15:0] EXP_A5 = 16'h00A5;
   localparam logic [15:0] EXP_05 = 16'h0005;
`else
   localparam int EXP_PULSES = 7;
   localparam int EXP_FV     = 65;
   localparam logic [15:0] EXP_A5 = 16'h01A5;
   localparam logic [15:0] EXP_05 = 16'h0105;
`endif

   logic clk = 1'b0;
   logic reset, en;
   logic [CH-1:0] pad_data;
   logic pad_latch, pad_clk, frame_valid, busy;
   logic [CH*BITS-1:0] buttons, pressed, released;
`ifdef SERIAL_PAD_PRESENT_EN
   logic [CH-1:0] present;
`endif

   always #5 clk = ~clk;

   serial_pad_poller #(
      .CHANNELS (CH),
      .BITS     (BITS),
      .HALF_DIV (4),
      .POLL_DIV (200)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .pad_data    (pad_data),
      .pad_latch   (pad_latch),
      .pad_clk     (pad_clk),
      .buttons     (buttons),
      .pressed     (pressed),
      .released    (released),
      .frame_valid (frame_valid),
      .busy        (busy)
`ifdef SERIAL_PAD_PRESENT_EN
      ,
      .present     (present)
`endif
   );

   // Pad model: parallel load while latched, shift on pad_clk rise, grounded serial in.
   logic [7:0] btn0 = 8'h00, btn1 = 8'h00;
   logic [7:0] sr0 = 8'hFF, sr1 = 8'hFF;
   logic prev_pclk = 1'b0;
   always @(negedge clk) begin
      if (pad_latch) begin
         sr0 = ~btn0;
         sr1 = ~btn1;
      end else if (pad_clk && !prev_pclk) begin
         sr0 = {1'b0, sr0[7:1]};
         sr1 = {1'b0, sr1[7:1]};
      end
      prev_pclk = pad_clk;
   end
`ifdef SERIAL_PAD_PRESENT_EN
   assign pad_data = {1'b1, sr0[0]};
`else
   assign pad_data = {sr1[0], sr0[0]};
`endif

   int checks = 0;
   int failures = 0;
   int m_latch, m_pulses, m_hi_min, m_hi_max, m_lo_min, m_lo_max, m_to_fv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_latch(input string tag);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pad_latch) break;
      end
      chk(tag, {31'd0, pad_latch}, 32'd1);
   endtask

   // Called on the first negedge with pad_latch high; runs to frame_valid.
   task automatic measure_frame(input string tag);
      int hi_run, lo_run;
      bit lo_on, prev;
      m_latch = 1; m_pulses = 0; m_to_fv = 0;
      m_hi_min = 999; m_hi_max = 0; m_lo_min = 999; m_lo_max = 0;
      hi_run = 0; lo_run = 0; lo_on = 1'b0; prev = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         m_to_fv++;
         if (pad_latch) m_latch++;
         if (pad_clk && !prev) begin
            m_pulses++;
            if (lo_on) begin
               if (lo_run < m_lo_min) m_lo_min = lo_run;
               if (lo_run > m_lo_max) m_lo_max = lo_run;
            end
            lo_on = 1'b0;
            hi_run = 1;
         end else if (pad_clk) begin
            hi_run++;
         end else if (prev) begin
            if (hi_run < m_hi_min) m_hi_min = hi_run;
            if (hi_run > m_hi_max) m_hi_max = hi_run;
            lo_on = 1'b1;
            lo_run = 1;
         end else if (lo_on) begin
            lo_run++;
         end
         prev = pad_clk;
         if (frame_valid) break;
      end
      chk({tag, "_fv_seen"}, {31'd0, frame_valid}, 32'd1);
   endtask

   initial begin
      int gap, cnt;
      reset = 1'b0;
      en    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_latch", {31'd0, pad_latch}, 32'd0);
      chk("rst_pclk", {31'd0, pad_clk}, 32'd0);
      chk("rst_buttons", {16'd0, buttons}, 32'd0);
      chk("rst_edges", {pressed, released}, 32'd0);
      chk("rst_fv_busy", {30'd0, frame_valid, busy}, 32'd0);
`ifdef SERIAL_PAD_PRESENT_EN
      chk("rst_present", {30'd0, present}, 32'd0);
`endif
      reset = 1'b1;
      en    = 1'b1;

      // Frame timing with idle pads.
      wait_latch("t2_latch");
      chk("t2_busy", {31'd0, busy}, 32'd1);
      measure_frame("t2");
      chk("t2_latch_len", m_latch, 32'd8);
      chk("t2_pulses", m_pulses, EXP_PULSES);
      chk("t2_hi_min", m_hi_min, 32'd4);
      chk("t2_hi_max", m_hi_max, 32'd4);
      chk("t2_lo_min", m_lo_min, 32'd4);
      chk("t2_lo_max", m_lo_max, 32'd4);
      chk("t2_to_fv", m_to_fv, EXP_FV);
      chk("t2_buttons", {16'd0, buttons}, 32'd0);
      chk("t2_edges", {pressed, released}, 32'd0);
      @(negedge clk);
      chk("t2_fv_one_cycle", {30'd0, frame_valid, busy}, 32'd0);

      // Presses on both channels, then an identical second frame.
      btn0 = 8'hA5;
      btn1 = 8'h01;
      wait_latch("t3_latch");
      measure_frame("t3a");
      chk("t3a_buttons", {16'd0, buttons}, {16'd0, EXP_A5});
      chk("t3a_pressed", {16'd0, pressed}, {16'd0, EXP_A5});
      chk("t3a_released", {16'd0, released}, 32'd0);
`ifdef SERIAL_PAD_PRESENT_EN
      chk("t6_present", {30'd0, present}, 32'd1);
`endif
      gap = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         gap++;
         if (frame_valid) break;
      end
      chk("t3_fv_period", gap, 32'd200);
      chk("t3b_buttons", {16'd0, buttons}, {16'd0, EXP_A5});
      chk("t3b_edges", {pressed, released}, 32'd0);

      // Release of the upper ch0 bits.
      btn0 = 8'h05;
      wait_latch("t4_latch");
      measure_frame("t4");
      chk("t4_buttons", {16'd0, buttons}, {16'd0, EXP_05});
      chk("t4_released", {16'd0, released}, 32'h0000_00A0);
      chk("t4_pressed", {16'd0, pressed}, 32'd0);
      @(negedge clk);
      chk("t4_rel_one_cycle", {16'd0, released}, 32'd0);

      // en dropped two cycles into LATCH: frame completes, no further frames.
      wait_latch("t5_latch");
      repeat (2) @(negedge clk);
      en = 1'b0;
      gap = 2;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         gap++;
         if (frame_valid) break;
      end
      chk("t5_fv_seen", {31'd0, frame_valid}, 32'd1);
      chk("t5_to_fv", gap, EXP_FV);
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (pad_latch || busy) cnt++;
      end
      chk("t5_no_latch", cnt, 32'd0);

      // Asynchronous reset in the middle of CLK_HI.
      en = 1'b1;
      wait_latch("t1_latch");
      for (int i = 0; i < 100; i++) begin
         if (pad_clk) break;
         @(negedge clk);
      end
      chk("t1_in_clk_hi", {31'd0, pad_clk}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("t1_async_buttons", {16'd0, buttons}, 32'd0);
      chk("t1_async_ctrl", {28'd0, pad_latch, pad_clk, frame_valid, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cnt++;
         if (pad_latch) break;
      end
      chk("t1_restart_delay", cnt, 32'd200);
      measure_frame("t1");
      chk("t1_buttons", {16'd0, buttons}, {16'd0, EXP_05});
      chk("t1_pressed", {16'd0, pressed}, {16'd0, EXP_05});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
